// File: rtl/noc_traffic_injector.sv
// Packet injector for one mesh node's local port: gap-paced, budget-limited, pattern-selected destinations.
// Optional: define INJ_TIMESTAMP_EN to stamp packets with a free-running cycle counter (else timestamp = 0).
module noc_traffic_injector #(
    parameter int                     COORD_W   = 3,
    parameter int                     MESH_X    = 3,
    parameter int                     MESH_Y    = 3,
    parameter logic [2*COORD_W-1:0]   SRC_ID    = 6'b010_010,
    parameter int                     PKT_W     = 56,
    parameter int                     PID_W     = 10,
    parameter int                     PAY_W     = 18,
    parameter int                     GAP       = 200,
    parameter int                     MAX_PKTS  = 1022,
    parameter int                     PATTERN   = 0,
    parameter logic [2*COORD_W-1:0]   DEST_ID   = 6'b000_000,
    parameter logic [15:0]            LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             dn_full,
    input  logic             gnt_dn,
    output logic             req_dn,
    output logic [PKT_W-1:0] pkt_out,
    output logic             busy,
    output logic             done,
    output logic [PID_W-1:0] sent_cnt,
    output logic [2:0]       dbgState
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] PREP       = 3'd1;
    localparam logic [2:0] GAP_WAIT   = 3'd2;
    localparam logic [2:0] SEND_REQ   = 3'd3;
    localparam logic [2:0] WAIT_GRANT = 3'd4;
    localparam logic [2:0] DONE       = 3'd5;

    localparam int GAP_CW   = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    logic [2:0]           state;
    logic [GAP_CW-1:0]    gapCnt;
    logic [PID_W-1:0]     pktId;
    logic [15:0]          lfsr;
    logic [15:0]          lfsrNext;
    logic [2*COORD_W-1:0] dest;
    logic [2*COORD_W-1:0] cand;
    logic [COORD_W-1:0]   candX;
    logic [COORD_W-1:0]   candY;
    logic                 candLegal;
    logic                 lastPkt;
    logic [PAY_W-1:0]     payload;
    logic [15:0]          tsField;

    // Fibonacci LFSR, taps 16,14,13,11
    assign lfsrNext = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    always_comb begin
        cand = DEST_ID;
        if (PATTERN == 1) begin
            cand = {lfsr[COORD_W-1:0], lfsr[2*COORD_W-1:COORD_W]};
        end else if (PATTERN == 2) begin
            cand = {SRC_ID[COORD_W-1:0], SRC_ID[2*COORD_W-1:COORD_W]};
        end
    end

    assign candX     = cand[2*COORD_W-1:COORD_W];
    assign candY     = cand[COORD_W-1:0];
    assign candLegal = (int'(candX) < MESH_X) && (int'(candY) < MESH_Y) && (cand != SRC_ID);
    assign lastPkt   = (MAX_PKTS != 0) && ((int'(sent_cnt) + 1) == MAX_PKTS);

    generate
        if (PAY_W > 16) begin : g_payWide
            assign payload = {{(PAY_W-16){1'b0}}, lfsr};
        end else begin : g_payNarrow
            assign payload = lfsr[PAY_W-1:0];
        end
    endgenerate

`ifdef INJ_TIMESTAMP_EN
    logic [15:0] tsCnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tsCnt <= 16'h0000;
        end else begin
            tsCnt <= tsCnt + 16'd1;
        end
    end

    assign tsField = tsCnt;
`else
    assign tsField = 16'h0000;
`endif

    // Handshake: req_dn rises together with pkt_out and both hold until gnt_dn is
    // sampled high while req_dn is high; gnt_dn with req_dn low is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            gapCnt   <= '0;
            pktId    <= '0;
            sent_cnt <= '0;
            lfsr     <= LFSR_SEED;
            dest     <= '0;
            req_dn   <= 1'b0;
            pkt_out  <= '0;
        end else begin
            if (state == PREP) begin
                lfsr <= lfsrNext;
            end
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= PREP;
                    end
                end
                PREP: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (candLegal) begin
                        dest   <= cand;
                        gapCnt <= '0;
                        state  <= (GAP == 0) ? SEND_REQ : GAP_WAIT;
                    end else if (PATTERN != 1) begin
                        // A fixed pattern that is illegal once is illegal forever
                        state <= DONE;
                    end
                end
                GAP_WAIT: begin
                    gapCnt <= gapCnt + 1'b1;
                    if (!enable) begin
                        state <= IDLE;
                    end else if (gapCnt == GAP_CW'(GAP_LAST)) begin
                        state <= SEND_REQ;
                    end
                end
                SEND_REQ: begin
                    if (!dn_full) begin
                        req_dn  <= 1'b1;
                        pkt_out <= {pktId, SRC_ID, dest, tsField, payload};
                        state   <= WAIT_GRANT;
                    end
                end
                WAIT_GRANT: begin
                    if (gnt_dn && req_dn) begin
                        req_dn   <= 1'b0;
                        pktId    <= pktId + 1'b1;
                        sent_cnt <= sent_cnt + 1'b1;
                        if (lastPkt) begin
                            state <= DONE;
                        end else if (enable) begin
                            state <= PREP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = (state != IDLE) && (state != DONE);
    assign done     = (state == DONE);
    assign dbgState = state;

endmodule

// File: tb/tb_noc_traffic_injector.sv
// Directed bench for noc_traffic_injector: six configurations sharing one clock and reset.
module tb_noc_traffic_injector;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_PREP = 3'd1, ST_GAP = 3'd2;
    localparam logic [2:0] ST_SEND = 3'd3, ST_WAIT = 3'd4, ST_DONE = 3'd5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic        en0 = 0, full0 = 0, gnt0 = 0, req0, busy0, done0;
    logic [55:0] pkt0;
    logic [9:0]  cnt0;
    logic [2:0]  dbg0;
    logic        en1 = 0, full1 = 0, gnt1 = 0, req1, busy1, done1;
    logic [55:0] pkt1;
    logic [9:0]  cnt1;
    logic [2:0]  dbg1;
    logic        en2 = 0, full2 = 0, gnt2 = 0, req2, busy2, done2;
    logic [55:0] pkt2;
    logic [9:0]  cnt2;
    logic [2:0]  dbg2;
    logic        en3 = 0, full3 = 0, gnt3 = 0, req3, busy3, done3;
    logic [55:0] pkt3;
    logic [9:0]  cnt3;
    logic [2:0]  dbg3;
    logic        en4 = 0, full4 = 0, gnt4 = 0, req4, busy4, done4;
    logic [55:0] pkt4;
    logic [9:0]  cnt4;
    logic [2:0]  dbg4;
    logic        en5 = 0, full5 = 0, gnt5 = 0, req5, busy5, done5;
    logic [49:0] pkt5;
    logic [3:0]  cnt5;
    logic [2:0]  dbg5;

    noc_traffic_injector #(.GAP(2), .PATTERN(0), .DEST_ID(6'b000_001)) u0 (
        .clk(clk), .reset(reset), .enable(en0), .dn_full(full0), .gnt_dn(gnt0), .req_dn(req0),
        .pkt_out(pkt0), .busy(busy0), .done(done0), .sent_cnt(cnt0), .dbgState(dbg0));
    noc_traffic_injector #(.GAP(0), .PATTERN(1), .MAX_PKTS(0)) u1 (
        .clk(clk), .reset(reset), .enable(en1), .dn_full(full1), .gnt_dn(gnt1), .req_dn(req1),
        .pkt_out(pkt1), .busy(busy1), .done(done1), .sent_cnt(cnt1), .dbgState(dbg1));
    noc_traffic_injector #(.GAP(0), .PATTERN(2), .SRC_ID(6'b001_010), .MAX_PKTS(0)) u2 (
        .clk(clk), .reset(reset), .enable(en2), .dn_full(full2), .gnt_dn(gnt2), .req_dn(req2),
        .pkt_out(pkt2), .busy(busy2), .done(done2), .sent_cnt(cnt2), .dbgState(dbg2));
    noc_traffic_injector #(.GAP(0), .PATTERN(2), .SRC_ID(6'b001_001)) u3 (
        .clk(clk), .reset(reset), .enable(en3), .dn_full(full3), .gnt_dn(gnt3), .req_dn(req3),
        .pkt_out(pkt3), .busy(busy3), .done(done3), .sent_cnt(cnt3), .dbgState(dbg3));
    noc_traffic_injector #(.GAP(0), .PATTERN(0), .DEST_ID(6'b000_001), .MAX_PKTS(3)) u4 (
        .clk(clk), .reset(reset), .enable(en4), .dn_full(full4), .gnt_dn(gnt4), .req_dn(req4),
        .pkt_out(pkt4), .busy(busy4), .done(done4), .sent_cnt(cnt4), .dbgState(dbg4));
    noc_traffic_injector #(.GAP(0), .PATTERN(0), .DEST_ID(6'b000_001), .MAX_PKTS(0),
                           .PID_W(4), .PKT_W(50)) u5 (
        .clk(clk), .reset(reset), .enable(en5), .dn_full(full5), .gnt_dn(gnt5), .req_dn(req5),
        .pkt_out(pkt5), .busy(busy5), .done(done5), .sent_cnt(cnt5), .dbgState(dbg5));

    // Immediate-grant responders: grant one cycle after a request is seen
    always @(negedge clk) begin
        gnt1 = req1;
        gnt2 = req2;
        gnt4 = req4;
        gnt5 = req5;
    end

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsrStep(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic destLegal(input logic [5:0] d);
        return (d[5:3] < 3'd3) && (d[2:0] < 3'd3) && (d != 6'b010_010);
    endfunction

    task automatic resetDut();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic waitReq0(input string tag, input int maxCyc);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < maxCyc; i++) begin
            @(negedge clk);
            if (req0) begin
                ok = 1'b1;
                break;
            end
        end
        checkEq(tag, ok, 1'b1);
    endtask

    task automatic waitState0(input string tag, input logic [2:0] st, input int maxCyc);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < maxCyc; i++) begin
            @(negedge clk);
            if (dbg0 == st) begin
                ok = 1'b1;
                break;
            end
        end
        checkEq(tag, ok, 1'b1);
    endtask

    logic [15:0] mdl0;
    logic [55:0] held;
    logic        flag;
    logic [23:0] expQ[$];
    logic [23:0] e;
    logic [15:0] lf;
    logic [5:0]  cnd;
    int          got;
    int          cyc;
    int          pulses;
    int          lastCyc;
    logic        prevReq;
    logic [3:0]  expId;
    logic [3:0]  prevCnt;

    initial begin
        // ---------------- u0: reset state, handshake, backpressure, disruption
        resetDut();
        checkEq("rst_req", req0, 1'b0);
        checkEq("rst_pkt", pkt0, 56'h0);
        checkEq("rst_busy", busy0, 1'b0);
        checkEq("rst_done", done0, 1'b0);
        checkEq("rst_cnt", cnt0, 10'd0);
        checkEq("rst_state", dbg0, ST_IDLE);
        checkEq("rst_pkt1", pkt1, 56'h0);

        mdl0 = 16'hACE1;
        en0 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checkEq($sformatf("hs_req_low%0d", i), req0, 1'b0);
            if (i == 1) checkEq("hs_prep", dbg0, ST_PREP);
        end
        @(negedge clk);
        checkEq("hs_req_rise", req0, 1'b1);
        mdl0 = lfsrStep(mdl0);
        checkEq("hs_pid0", pkt0[55:46], 10'd0);
        checkEq("hs_src", pkt0[45:40], 6'b010_010);
        checkEq("hs_dest", pkt0[39:34], 6'b000_001);
`ifndef INJ_TIMESTAMP_EN
        checkEq("hs_ts", pkt0[33:18], 16'h0);
`endif
        checkEq("hs_payload", pkt0[17:0], {2'b00, mdl0});
        gnt0 = 1'b1;
        @(negedge clk);
        gnt0 = 1'b0;
        checkEq("hs_req_drop", req0, 1'b0);
        checkEq("hs_sent1", cnt0, 10'd1);
        checkEq("hs_busy", busy0, 1'b1);

        waitReq0("hs_wait2", 10);
        mdl0 = lfsrStep(mdl0);
        checkEq("hs_pid1", pkt0[55:46], 10'd1);
        checkEq("hs_payload2", pkt0[17:0], {2'b00, mdl0});
        gnt0 = 1'b1;
        @(negedge clk);
        gnt0 = 1'b0;
        checkEq("hs_sent2", cnt0, 10'd2);

        full0 = 1'b1;
        waitState0("bp_reach_send", ST_SEND, 10);
        flag = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (req0 || dbg0 != ST_SEND) flag = 1'b1;
        end
        checkEq("bp_hold_low", flag, 1'b0);
        full0 = 1'b0;
        @(negedge clk);
        checkEq("bp_rise", req0, 1'b1);
        checkEq("bp_pid2", pkt0[55:46], 10'd2);

        held = pkt0;
        en0 = 1'b0;
        full0 = 1'b1;
        flag = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (!req0 || pkt0 !== held) flag = 1'b1;
        end
        checkEq("gw_stable", flag, 1'b0);
        gnt0 = 1'b1;
        @(negedge clk);
        gnt0 = 1'b0;
        full0 = 1'b0;
        checkEq("gw_req_drop", req0, 1'b0);
        checkEq("gw_sent3", cnt0, 10'd3);
        checkEq("gw_idle", dbg0, ST_IDLE);

        en0 = 1'b1;
        waitState0("ge_reach_gap", ST_GAP, 10);
        en0 = 1'b0;
        @(negedge clk);
        checkEq("ge_idle", dbg0, ST_IDLE);
        flag = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (req0) flag = 1'b1;
        end
        checkEq("ge_no_req", flag, 1'b0);

        en0 = 1'b1;
        waitReq0("ar_wait_req", 10);
        checkEq("ar_in_wait", dbg0, ST_WAIT);
        #2 reset = 1'b0;
        #1;
        checkEq("ar_req", req0, 1'b0);
        checkEq("ar_pkt", pkt0, 56'h0);
        checkEq("ar_cnt", cnt0, 10'd0);
        checkEq("ar_state", dbg0, ST_IDLE);
        en0 = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // ---------------- u1: uniform random, two identical runs against the LFSR model
        for (int run = 0; run < 2; run++) begin
            resetDut();
            expQ.delete();
            lf = 16'hACE1;
            for (int n = 0; n < 200; n++) begin
                do begin
                    cnd = {lf[2:0], lf[5:3]};
                    lf = lfsrStep(lf);
                end while (!destLegal(cnd));
                expQ.push_back({lf, 2'b00, cnd});
            end
            en1 = 1'b1;
            got = 0;
            cyc = 0;
            while (got < 200 && cyc < 20000) begin
                @(negedge clk);
                cyc++;
                if (req1) begin
                    e = expQ.pop_front();
                    checkEq($sformatf("p1_dest_r%0d_n%0d", run, got), pkt1[39:34], e[5:0]);
                    checkEq($sformatf("p1_pay_r%0d_n%0d", run, got), pkt1[17:0], {2'b00, e[23:8]});
                    checkEq($sformatf("p1_range_r%0d_n%0d", run, got), destLegal(pkt1[39:34]), 1'b1);
                    got++;
                end
            end
            checkEq($sformatf("p1_count_r%0d", run), got, 200);
            en1 = 1'b0;
        end

        // ---------------- u2: transpose
        resetDut();
        en2 = 1'b1;
        got = 0;
        for (int i = 0; i < 100 && got < 5; i++) begin
            @(negedge clk);
            if (req2) begin
                checkEq("p2_dest", pkt2[39:34], 6'b010_001);
                checkEq("p2_src", pkt2[45:40], 6'b001_010);
                got++;
            end
        end
        checkEq("p2_count", got, 5);
        en2 = 1'b0;

        // ---------------- u3: transpose onto itself
        resetDut();
        en3 = 1'b1;
        flag = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (req3) flag = 1'b1;
        end
        checkEq("p3_done", done3, 1'b1);
        checkEq("p3_busy", busy3, 1'b0);
        checkEq("p3_state", dbg3, ST_DONE);
        checkEq("p3_no_req", flag, 1'b0);
        en3 = 1'b0;

        // ---------------- u4: budget of 3, minimum period
        resetDut();
        en4 = 1'b1;
        pulses = 0;
        lastCyc = 0;
        flag = 1'b0;
        prevReq = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (prevReq && pulses == 3) checkEq("p4_done_at_grant", done4, 1'b1);
            if (req4) begin
                pulses++;
                if (pulses > 1 && c - lastCyc != 3) flag = 1'b1;
                if (pulses == 3) checkEq("p4_not_done_early", done4, 1'b0);
                lastCyc = c;
            end
            prevReq = req4;
        end
        checkEq("p4_pulses", pulses, 3);
        checkEq("p4_period", flag, 1'b0);
        checkEq("p4_done", done4, 1'b1);
        checkEq("p4_sent", cnt4, 10'd3);
        en4 = 1'b0;

        // ---------------- u5: 4-bit packet ID wrap
        resetDut();
        en5 = 1'b1;
        expId = 4'd0;
        prevCnt = 4'd0;
        flag = 1'b0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (req5) begin
                checkEq("p5_pid", pkt5[49:46], expId);
                expId = expId + 4'd1;
            end
            if (prevCnt == 4'd15 && cnt5 == 4'd0) flag = 1'b1;
            prevCnt = cnt5;
        end
        checkEq("p5_wrap", flag, 1'b1);
        en5 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
